// File: rtl/msrh_stq_wc_entry_if.sv
// Signal bundle between the write-combining store entry and its neighbours:
// committed-store drain, L1D line write port, LRQ resolve and snoop pipe.
interface msrh_stq_wc_entry_if #(
    parameter int PADDR_W   = 56,
    parameter int LINE_B    = 64,
    parameter int ST_DATA_W = 64,
    parameter int LRQ_SIZE  = 8
);
    logic                   i_st_valid;
    logic [PADDR_W-1:0]     i_st_paddr;
    logic [ST_DATA_W-1:0]   i_st_data;
    logic [ST_DATA_W/8-1:0] i_st_be;
    logic                   o_st_accept;
    logic                   i_flush_req;
    logic                   o_busy;
    logic                   o_l1d_req_valid;
    logic                   i_l1d_req_ready;
    logic [PADDR_W-1:0]     o_l1d_paddr;
    logic [LINE_B*8-1:0]    o_l1d_data;
    logic [LINE_B-1:0]      o_l1d_be;
    logic                   i_l1d_resp_valid;
    logic                   i_l1d_resp_miss;
    logic                   i_l1d_resp_conflict;
    logic [LRQ_SIZE-1:0]    i_lrq_index_oh;
    logic                   i_lrq_resolve_valid;
    logic [LRQ_SIZE-1:0]    i_lrq_resolve_index_oh;
    logic                   i_snoop_req_valid;
    logic [PADDR_W-1:0]     i_snoop_paddr;
    logic                   o_snoop_resp_valid;
    logic [LINE_B-1:0]      o_snoop_resp_be;
    logic [LINE_B*8-1:0]    o_snoop_resp_data;

    modport slave (
        input  i_st_valid, i_st_paddr, i_st_data, i_st_be, i_flush_req,
        input  i_l1d_req_ready, i_l1d_resp_valid, i_l1d_resp_miss, i_l1d_resp_conflict,
        input  i_lrq_index_oh, i_lrq_resolve_valid, i_lrq_resolve_index_oh,
        input  i_snoop_req_valid, i_snoop_paddr,
        output o_st_accept, o_busy, o_l1d_req_valid, o_l1d_paddr, o_l1d_data, o_l1d_be,
        output o_snoop_resp_valid, o_snoop_resp_be, o_snoop_resp_data
    );

    modport master (
        output i_st_valid, i_st_paddr, i_st_data, i_st_be, i_flush_req,
        output i_l1d_req_ready, i_l1d_resp_valid, i_l1d_resp_miss, i_l1d_resp_conflict,
        output i_lrq_index_oh, i_lrq_resolve_valid, i_lrq_resolve_index_oh,
        output i_snoop_req_valid, i_snoop_paddr,
        input  o_st_accept, o_busy, o_l1d_req_valid, o_l1d_paddr, o_l1d_data, o_l1d_be,
        input  o_snoop_resp_valid, o_snoop_resp_be, o_snoop_resp_data
    );
endinterface

// File: rtl/msrh_stq_wc_entry.sv
// Write-combining store buffer entry: merges committed stores to one line, issues a
// single L1D line write with miss/LRQ and conflict replay, and answers snoops.
module msrh_stq_wc_entry #(
    parameter int PADDR_W       = 56,
    parameter int LINE_B        = 64,
    parameter int ST_DATA_W     = 64,
    parameter int MERGE_TIMEOUT = 8,
    parameter int LRQ_SIZE      = 8
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    msrh_stq_wc_entry_if.slave bus
);
    localparam int ST_B   = ST_DATA_W / 8;
    localparam int LINE_W = LINE_B * 8;
    localparam int OFF_W  = $clog2(LINE_B);
    localparam int SUB_W  = $clog2(ST_B);
    localparam int SLOTS  = LINE_B / ST_B;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CNT_W  = (MERGE_TIMEOUT > 1) ? $clog2(MERGE_TIMEOUT) : 1;
    localparam int TAG_W  = PADDR_W - OFF_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MERGE,
        S_REQ,
        S_CHECK,
        S_LRQ_WAIT
    } state_t;

    state_t              state;
    logic [TAG_W-1:0]    line_tag;
    logic [LINE_B-1:0]   line_be;
    logic [LINE_W-1:0]   line_data;
    logic [CNT_W-1:0]    idle_cnt;
    logic [LRQ_SIZE-1:0] lrq_idx;

    logic [SLOT_W-1:0]   st_slot;
    logic                same_line;
    logic                accept;
    logic                timeout;
    logic                snoop_hit;
    logic [LINE_B-1:0]   st_be_line;
    logic [LINE_W-1:0]   st_data_line;
    logic [LINE_W-1:0]   st_mask;
    logic [LINE_W-1:0]   line_mask;
    logic [LINE_B-1:0]   base_be;
    logic [LINE_W-1:0]   base_data;
    logic [LINE_B-1:0]   merged_be;
    logic [LINE_W-1:0]   merged_data;

    logic                snoop_valid_q;
    logic [LINE_B-1:0]   snoop_be_q;
    logic [LINE_W-1:0]   snoop_data_q;

    logic                unused_snoop_offset;
    assign unused_snoop_offset = ^bus.i_snoop_paddr[OFF_W-1:0];

    assign st_slot   = SLOT_W'((bus.i_st_paddr >> SUB_W) & (SLOTS - 1));
    assign same_line = (bus.i_st_paddr[PADDR_W-1:OFF_W] == line_tag);
    assign accept    = bus.i_st_valid && ((state == S_IDLE) || (state == S_MERGE && same_line));
    assign timeout   = (idle_cnt == CNT_W'(MERGE_TIMEOUT - 1));
    assign snoop_hit = bus.i_snoop_req_valid && (state != S_IDLE) &&
                       (bus.i_snoop_paddr[PADDR_W-1:OFF_W] == line_tag);

    // A fresh line starts from an empty image, so the IDLE load never sees stale bytes.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        st_be_line   = '0;
        st_data_line = '0;
        if (accept) begin
            st_be_line   = LINE_B'(bus.i_st_be) << (int'(st_slot) * ST_B);
            st_data_line = LINE_W'(bus.i_st_data) << (int'(st_slot) * ST_DATA_W);
        end
        base_be   = (state == S_IDLE) ? '0 : line_be;
        base_data = (state == S_IDLE) ? '0 : line_data;
        for (int i = 0; i < LINE_B; i++) begin
            st_mask[i*8 +: 8]   = {8{st_be_line[i]}};
            line_mask[i*8 +: 8] = {8{line_be[i]}};
        end
        merged_be   = base_be | st_be_line;
        merged_data = (base_data & ~st_mask) | (st_data_line & st_mask);
    end

    // NOTE: sequential state uses non-blocking assignments only; the line image is reset
    // as well because a reset must discard whatever was being combined.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= S_IDLE;
            line_tag  <= '0;
            line_be   <= '0;
            line_data <= '0;
            idle_cnt  <= '0;
            lrq_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        line_tag  <= bus.i_st_paddr[PADDR_W-1:OFF_W];
                        line_be   <= merged_be;
                        line_data <= merged_data;
                        idle_cnt  <= '0;
                        state     <= S_MERGE;
                    end
                end
                S_MERGE: begin
                    if (accept) begin
                        line_be   <= merged_be;
                        line_data <= merged_data;
                        idle_cnt  <= '0;
                    end else if (!timeout) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    // A store to another line is refused but still forces the current line out.
                    if (bus.i_flush_req || (&merged_be) || (bus.i_st_valid && !accept) ||
                        (!accept && timeout)) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.i_l1d_req_ready) state <= S_CHECK;
                end
                S_CHECK: begin
                    if (bus.i_l1d_resp_valid) begin
                        if (bus.i_l1d_resp_miss) begin
                            lrq_idx <= bus.i_lrq_index_oh;
                            state   <= S_LRQ_WAIT;
                        end else if (bus.i_l1d_resp_conflict) begin
                            state <= S_REQ;
                        end else begin
                            line_be   <= '0;
                            line_data <= '0;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_LRQ_WAIT: begin
                    // An all-zero index means a fresh LRQ allocation: just retry.
                    if ((lrq_idx == '0) ||
                        (bus.i_lrq_resolve_valid && (bus.i_lrq_resolve_index_oh == lrq_idx))) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Snoop answers from the image held before this cycle's merge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            snoop_valid_q <= 1'b0;
            snoop_be_q    <= '0;
            snoop_data_q  <= '0;
        end else begin
            snoop_valid_q <= bus.i_snoop_req_valid;
            snoop_be_q    <= snoop_hit ? line_be : '0;
            snoop_data_q  <= snoop_hit ? (line_data & line_mask) : '0;
        end
    end

    assign bus.o_st_accept        = accept;
    assign bus.o_busy             = (state != S_IDLE);
    assign bus.o_l1d_req_valid    = (state == S_REQ);
    assign bus.o_l1d_paddr        = {line_tag, OFF_W'(0)};
    assign bus.o_l1d_data         = line_data;
    assign bus.o_l1d_be           = line_be;
    assign bus.o_snoop_resp_valid = snoop_valid_q;
    assign bus.o_snoop_resp_be    = snoop_be_q;
    assign bus.o_snoop_resp_data  = snoop_data_q;
endmodule

// File: tb/tb_msrh_stq_wc_entry.sv
// Self-checking bench for msrh_stq_wc_entry: table-driven single-store lines, a scoreboard
// of expected L1D line writes, and hand-written merge/replay/LRQ/snoop sequences.
module tb_msrh_stq_wc_entry;
    localparam int PADDR_W = 56;
    localparam int LINE_B  = 64;
    localparam int ST_W    = 64;
    localparam int TMO     = 8;
    localparam int LRQ_N   = 8;
    localparam int LW      = LINE_B * 8;

    typedef struct {
        logic [PADDR_W-1:0] addr;
        logic [LINE_B-1:0]  be;
        logic [LW-1:0]      data;
    } line_t;

    typedef struct {
        logic             miss;
        logic             conflict;
        logic [LRQ_N-1:0] idx;
    } resp_t;

    typedef struct {
        logic [PADDR_W-1:0] paddr;
        logic [7:0]         be;
        logic [ST_W-1:0]    data;
        logic [PADDR_W-1:0] exp_line;
        int                 exp_off;
    } vec_t;

    logic clk;
    logic i_reset_n;
    int   n_checks;
    int   n_fail;
    int   hs_count;
    logic resp_due;

    line_t exp_q[$];
    resp_t resp_q[$];
    resp_t cur;
    vec_t  vecs[5];

    logic [PADDR_W-1:0] m_addr;
    logic [LINE_B-1:0]  m_be;
    logic [LW-1:0]      m_data;

    msrh_stq_wc_entry_if #(.PADDR_W(PADDR_W), .LINE_B(LINE_B), .ST_DATA_W(ST_W),
                           .LRQ_SIZE(LRQ_N)) bus ();

    msrh_stq_wc_entry #(.PADDR_W(PADDR_W), .LINE_B(LINE_B), .ST_DATA_W(ST_W),
                        .MERGE_TIMEOUT(TMO), .LRQ_SIZE(LRQ_N)) dut (
        .i_clk    (clk),
        .i_reset_n(i_reset_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_clear(input logic [PADDR_W-1:0] a);
        m_addr = {a[PADDR_W-1:6], 6'b0};
        m_be   = '0;
        m_data = '0;
    endtask

    task automatic model_merge(input logic [PADDR_W-1:0] a, input logic [ST_W-1:0] d,
                               input logic [7:0] be);
        int off;
        off = int'(a[5:3]) * 8;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) begin
                m_be[off + b]            = 1'b1;
                m_data[(off + b)*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    task automatic push_exp();
        line_t e;
        e.addr = m_addr;
        e.be   = m_be;
        e.data = m_data;
        exp_q.push_back(e);
    endtask

    task automatic push_resp(input logic miss, input logic conflict, input logic [LRQ_N-1:0] idx);
        resp_t r;
        r.miss     = miss;
        r.conflict = conflict;
        r.idx      = idx;
        resp_q.push_back(r);
    endtask

    // Called just after a falling edge; offers one store for one cycle.
    task automatic store(input string name, input logic [PADDR_W-1:0] a,
                         input logic [ST_W-1:0] d, input logic [7:0] be, input logic exp_acc);
        bus.i_st_valid = 1'b1;
        bus.i_st_paddr = a;
        bus.i_st_data  = d;
        bus.i_st_be    = be;
        #1;
        check({name, "_accept"}, LW'(bus.o_st_accept), LW'(exp_acc));
        @(negedge clk);
        bus.i_st_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.i_flush_req = 1'b1;
        @(negedge clk);
        bus.i_flush_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!bus.o_busy) break;
            @(negedge clk);
        end
        check({name, "_idle"}, LW'(bus.o_busy), '0);
    endtask

    // L1D model: accepts every request, compares its payload with the scoreboard and
    // answers one cycle later with the next queued response (plain success by default).
    initial begin
        bus.i_l1d_req_ready     = 1'b1;
        bus.i_l1d_resp_valid    = 1'b0;
        bus.i_l1d_resp_miss     = 1'b0;
        bus.i_l1d_resp_conflict = 1'b0;
        bus.i_lrq_index_oh      = '0;
        resp_due = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_l1d_resp_valid    = 1'b0;
            bus.i_l1d_resp_miss     = 1'b0;
            bus.i_l1d_resp_conflict = 1'b0;
            bus.i_lrq_index_oh      = '0;
            if (resp_due) begin
                resp_due = 1'b0;
                bus.i_l1d_resp_valid    = 1'b1;
                bus.i_l1d_resp_miss     = cur.miss;
                bus.i_l1d_resp_conflict = cur.conflict;
                bus.i_lrq_index_oh      = cur.idx;
            end
            if (i_reset_n && bus.o_l1d_req_valid && bus.i_l1d_req_ready) begin
                hs_count++;
                check("l1d_req_expected", LW'(exp_q.size() != 0), LW'(1));
                if (exp_q.size() != 0) begin
                    line_t e;
                    e = exp_q.pop_front();
                    check("l1d_paddr", LW'(bus.o_l1d_paddr), LW'(e.addr));
                    check("l1d_be", LW'(bus.o_l1d_be), LW'(e.be));
                    check("l1d_data", bus.o_l1d_data, e.data);
                end
                if (resp_q.size() != 0) begin
                    cur = resp_q.pop_front();
                end else begin
                    cur.miss     = 1'b0;
                    cur.conflict = 1'b0;
                    cur.idx      = '0;
                end
                resp_due = 1'b1;
            end
        end
    end

    initial begin
        int base;
        int cnt;
        logic [LINE_B-1:0] pre_be;
        logic [LW-1:0]     pre_data;

        n_checks = 0;
        n_fail   = 0;
        hs_count = 0;
        i_reset_n = 1'b0;
        bus.i_st_valid             = 1'b0;
        bus.i_st_paddr             = '0;
        bus.i_st_data              = '0;
        bus.i_st_be                = '0;
        bus.i_flush_req            = 1'b0;
        bus.i_lrq_resolve_valid    = 1'b0;
        bus.i_lrq_resolve_index_oh = '0;
        bus.i_snoop_req_valid      = 1'b0;
        bus.i_snoop_paddr          = '0;

        vecs[0] = '{56'h0000_1000, 8'h0F, 64'h0000_0000_1122_3344, 56'h0000_1000, 0};
        vecs[1] = '{56'h0000_2048, 8'hF0, 64'hAABB_CCDD_0000_0000, 56'h0000_2040, 8};
        vecs[2] = '{56'h0000_33F8, 8'h81, 64'h8877_6655_4433_2211, 56'h0000_33C0, 56};
        vecs[3] = '{56'hFF_FFFF_FFFF_FFE0, 8'hFF, 64'h0123_4567_89AB_CDEF, 56'hFF_FFFF_FFFF_FFC0, 32};
        vecs[4] = '{56'h0000_0010, 8'h3C, 64'h0011_2233_4455_6677, 56'h0000_0000, 16};

        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", LW'(bus.o_busy), '0);
        check("rst_req_valid", LW'(bus.o_l1d_req_valid), '0);
        check("rst_l1d_be", LW'(bus.o_l1d_be), '0);
        check("rst_l1d_paddr", LW'(bus.o_l1d_paddr), '0);
        check("rst_l1d_data", bus.o_l1d_data, '0);
        check("rst_snoop_valid", LW'(bus.o_snoop_resp_valid), '0);
        @(negedge clk);
        i_reset_n = 1'b1;
        @(negedge clk);

        // Single-store lines: slot placement and line address from a table.
        for (int v = 0; v < 5; v++) begin
            line_t e;
            e.addr = vecs[v].exp_line;
            e.be   = '0;
            e.data = '0;
            for (int b = 0; b < 8; b++) begin
                if (vecs[v].be[b]) begin
                    e.be[vecs[v].exp_off + b]            = 1'b1;
                    e.data[(vecs[v].exp_off + b)*8 +: 8] = vecs[v].data[b*8 +: 8];
                end
            end
            exp_q.push_back(e);
            check("vec_idle_before", LW'(bus.o_busy), '0);
            store("vec", vecs[v].paddr, vecs[v].data, vecs[v].be, 1'b1);
            check("vec_busy_after", LW'(bus.o_busy), LW'(1));
            pulse_flush();
            wait_idle("vec");
        end

        // Merge timeout: MERGE_TIMEOUT idle cycles in MERGE, then the request.
        base = hs_count;
        model_clear(56'h1000);
        model_merge(56'h1000, 64'h1122_3344, 8'h0F);
        push_exp();
        store("t1", 56'h1000, 64'h1122_3344, 8'h0F, 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_l1d_req_valid) break;
            if (bus.o_busy) cnt++;
            @(negedge clk);
        end
        check("t1_merge_cycles", LW'(cnt), LW'(TMO));
        check("t1_req_valid", LW'(bus.o_l1d_req_valid), LW'(1));
        wait_idle("t1");
        check("t1_handshakes", LW'(hs_count - base), LW'(1));

        // Overwrite merge: later byte wins, one request only.
        base = hs_count;
        model_clear(56'h1000);
        model_merge(56'h1000, 64'hF0E0_D0C0_B0A0_9080, 8'hFF);
        model_merge(56'h1000, 64'h0000_0000_0000_00AA, 8'h01);
        push_exp();
        store("t2a", 56'h1000, 64'hF0E0_D0C0_B0A0_9080, 8'hFF, 1'b1);
        store("t2b", 56'h1000, 64'h0000_0000_0000_00AA, 8'h01, 1'b1);
        pulse_flush();
        wait_idle("t2");
        check("t2_handshakes", LW'(hs_count - base), LW'(1));

        // Store to another line closes the current one; it is taken later from IDLE.
        base = hs_count;
        model_clear(56'h1000);
        model_merge(56'h1000, 64'h5555, 8'h03);
        push_exp();
        store("t3a", 56'h1000, 64'h5555, 8'h03, 1'b1);
        bus.i_st_valid = 1'b1;
        bus.i_st_paddr = 56'h2040;
        bus.i_st_data  = 64'h77;
        bus.i_st_be    = 8'h01;
        #1;
        check("t3_other_line_rejected", LW'(bus.o_st_accept), '0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (bus.o_st_accept) break;
        end
        check("t3_accept_later", LW'(bus.o_st_accept), LW'(1));
        check("t3_accept_in_idle", LW'(bus.o_busy), '0);
        @(negedge clk);
        bus.i_st_valid = 1'b0;
        model_clear(56'h2040);
        model_merge(56'h2040, 64'h77, 8'h01);
        push_exp();
        pulse_flush();
        wait_idle("t3");
        check("t3_handshakes", LW'(hs_count - base), LW'(2));

        // Miss on LRQ entry 0x04: a non-matching resolve is ignored.
        base = hs_count;
        push_resp(1'b1, 1'b0, 8'h04);
        model_clear(56'h5000);
        model_merge(56'h5000, 64'hDEAD_BEEF, 8'h0F);
        push_exp();
        push_exp();
        store("t4", 56'h5000, 64'hDEAD_BEEF, 8'h0F, 1'b1);
        pulse_flush();
        for (int i = 0; i < 50; i++) begin
            if (hs_count > base) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("t4_lrq_wait_busy", LW'(bus.o_busy), LW'(1));
        check("t4_lrq_wait_no_req", LW'(bus.o_l1d_req_valid), '0);
        bus.i_lrq_resolve_valid    = 1'b1;
        bus.i_lrq_resolve_index_oh = 8'h02;
        @(negedge clk);
        bus.i_lrq_resolve_valid = 1'b0;
        check("t4_wrong_idx_no_req", LW'(bus.o_l1d_req_valid), '0);
        @(negedge clk);
        check("t4_wrong_idx_still_wait", LW'(bus.o_l1d_req_valid), '0);
        bus.i_lrq_resolve_valid    = 1'b1;
        bus.i_lrq_resolve_index_oh = 8'h04;
        @(negedge clk);
        bus.i_lrq_resolve_valid = 1'b0;
        check("t4_resolved_req", LW'(bus.o_l1d_req_valid), LW'(1));
        wait_idle("t4");
        check("t4_handshakes", LW'(hs_count - base), LW'(2));

        // Miss with a zero index retries on its own; miss takes priority over conflict.
        base = hs_count;
        push_resp(1'b1, 1'b1, 8'h00);
        model_clear(56'h5100);
        model_merge(56'h5100, 64'h1234, 8'h03);
        push_exp();
        push_exp();
        store("t4b", 56'h5100, 64'h1234, 8'h03, 1'b1);
        pulse_flush();
        wait_idle("t4b");
        check("t4b_handshakes", LW'(hs_count - base), LW'(2));

        // Two conflicts then success: three identical handshakes.
        base = hs_count;
        push_resp(1'b0, 1'b1, 8'h00);
        push_resp(1'b0, 1'b1, 8'h00);
        model_clear(56'h4400);
        model_merge(56'h4408, 64'hCAFE_F00D_0000_0001, 8'hFF);
        repeat (3) push_exp();
        store("t5", 56'h4408, 64'hCAFE_F00D_0000_0001, 8'hFF, 1'b1);
        pulse_flush();
        wait_idle("t5");
        check("t5_handshakes", LW'(hs_count - base), LW'(3));
        check("t5_busy_low", LW'(bus.o_busy), '0);

        // Snoop: hit returns held bytes, other line returns zero, same-cycle merge not visible.
        model_clear(56'h1000);
        model_merge(56'h1000, 64'h0102_0304_0506_0708, 8'hFF);
        model_merge(56'h1008, 64'h0000_0000_A1B2_C3D4, 8'h0F);
        store("t6a", 56'h1000, 64'h0102_0304_0506_0708, 8'hFF, 1'b1);
        store("t6b", 56'h1008, 64'h0000_0000_A1B2_C3D4, 8'h0F, 1'b1);
        bus.i_snoop_req_valid = 1'b1;
        bus.i_snoop_paddr     = 56'h1008;
        @(negedge clk);
        bus.i_snoop_paddr = 56'h3000;
        check("t6_hit_valid", LW'(bus.o_snoop_resp_valid), LW'(1));
        check("t6_hit_be", LW'(bus.o_snoop_resp_be), LW'(m_be));
        check("t6_hit_data", bus.o_snoop_resp_data, m_data);
        @(negedge clk);
        check("t6_miss_valid", LW'(bus.o_snoop_resp_valid), LW'(1));
        check("t6_miss_be", LW'(bus.o_snoop_resp_be), '0);
        check("t6_miss_data", bus.o_snoop_resp_data, '0);
        pre_be   = m_be;
        pre_data = m_data;
        model_merge(56'h1010, 64'h1111_2222_3333_4444, 8'hFF);
        push_exp();
        bus.i_snoop_paddr = 56'h1010;
        store("t6c", 56'h1010, 64'h1111_2222_3333_4444, 8'hFF, 1'b1);
        bus.i_snoop_req_valid = 1'b0;
        check("t6_pre_merge_be", LW'(bus.o_snoop_resp_be), LW'(pre_be));
        check("t6_pre_merge_data", bus.o_snoop_resp_data, pre_data);
        @(negedge clk);
        check("t6_no_req_valid", LW'(bus.o_snoop_resp_valid), '0);
        pulse_flush();
        wait_idle("t6");
        bus.i_snoop_req_valid = 1'b1;
        bus.i_snoop_paddr     = 56'h1000;
        @(negedge clk);
        bus.i_snoop_req_valid = 1'b0;
        check("t6_idle_snoop_be", LW'(bus.o_snoop_resp_be), '0);

        // Store together with flush: merged, then closed.
        model_clear(56'h7000);
        model_merge(56'h7000, 64'h01, 8'h01);
        model_merge(56'h7008, 64'h0200, 8'h02);
        push_exp();
        store("t7a", 56'h7000, 64'h01, 8'h01, 1'b1);
        bus.i_flush_req = 1'b1;
        store("t7b", 56'h7008, 64'h0200, 8'h02, 1'b1);
        bus.i_flush_req = 1'b0;
        check("t7_flush_req", LW'(bus.o_l1d_req_valid), LW'(1));
        wait_idle("t7");

        // A completely written line closes without flush or timeout.
        model_clear(56'h6000);
        for (int k = 0; k < 8; k++) model_merge(56'h6000 + 56'(k*8), 64'(k + 1) * 64'h0101, 8'hFF);
        push_exp();
        for (int k = 0; k < 8; k++) store("t8", 56'h6000 + 56'(k*8), 64'(k + 1) * 64'h0101, 8'hFF, 1'b1);
        check("t8_full_req", LW'(bus.o_l1d_req_valid), LW'(1));
        wait_idle("t8");

        // Store arriving in the timeout cycle keeps the line open.
        model_clear(56'h9000);
        model_merge(56'h9000, 64'h99, 8'h01);
        model_merge(56'h9018, 64'h88, 8'h01);
        push_exp();
        store("t9a", 56'h9000, 64'h99, 8'h01, 1'b1);
        repeat (TMO - 1) @(negedge clk);
        store("t9b", 56'h9018, 64'h88, 8'h01, 1'b1);
        check("t9_merge_wins_no_req", LW'(bus.o_l1d_req_valid), '0);
        check("t9_merge_wins_busy", LW'(bus.o_busy), LW'(1));
        pulse_flush();
        wait_idle("t9");

        // Reset in MERGE drops the line; a later flush issues nothing.
        base = hs_count;
        store("t10", 56'h8000, 64'hFFFF, 8'hFF, 1'b1);
        i_reset_n = 1'b0;
        #1;
        check("t10_rst_busy", LW'(bus.o_busy), '0);
        check("t10_rst_be", LW'(bus.o_l1d_be), '0);
        @(negedge clk);
        i_reset_n = 1'b1;
        pulse_flush();
        repeat (3) @(negedge clk);
        check("t10_no_req", LW'(bus.o_l1d_req_valid), '0);
        check("t10_no_handshake", LW'(hs_count - base), '0);

        check("scoreboard_empty", LW'(exp_q.size()), '0);
        check("resp_queue_empty", LW'(resp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
